// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, build-time overlap mode
// and a saturating match counter. All outputs are registered.
module seq_detector_param #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             en,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              match;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        y_d     = 1'b0;
        cnt_d   = cnt_q;
        match   = 1'b0;
        hist_n  = {hist_q[PAT_W-2:0], x};
        fill_n  = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);

        if (pat_ld) begin
            // A new pattern restarts the window; in-flight bits are discarded.
            pat_d  = pat_in;
            fill_d = '0;
            hist_d = '0;
        end else if (en) begin
            match  = (fill_n == FULL) && (hist_n == pat_q);
            hist_d = hist_n;
            y_d    = match;
            fill_d = (match && !OVERLAP) ? '0 : fill_n;
        end

        // Clear wins over a coincident match.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        armed_d = (fill_d == FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector. It samples one bit per enabled clock, compares the last PAT_W bits against a runtime-loadable pattern, and pulses `y` on a match. Overlapping or non-overlapping detection is fixed at build time, and a saturating match counter is included. It replaces the fixed-pattern Mealy/Moore sequence detector used in the serial-input control path and keeps the `x`/`y`/`clk`/`rst` port naming.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern loaded at reset; PAT_W bits wide; MSB is the oldest bit.
- OVERLAP, 1: 1 = overlapping detection; 0 = history cleared after each match.
- CNT_W, 8: match counter width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit; sampled only when `en`=1.
- en  in  1  bit-valid qualifier.
- pat_ld  in  1  synchronous pattern load strobe.
- pat_in  in  PAT_W  new pattern; captured when `pat_ld`=1.
- cnt_clr  in  1  synchronous clear of `match_cnt`.
- y  out  1  match pulse; one cycle per detected match.
- match_cnt  out  CNT_W  number of matches since reset or clear; saturates.
- armed  out  1  high when `fill`==PAT_W, i.e. a full window is held.

## Operation
- Internal state:
  - `hist[PAT_W-1:0]`: shift register; newest bit is in the LSB.
  - `fill`: 0..PAT_W; number of valid bits held in `hist`.
  - `pat[PAT_W-1:0]`: the active pattern.
- Reset (`rst`=0, asynchronous):
  - `hist`=0, `fill`=0, `pat`=PATTERN.
  - `y`=0, `match_cnt`=0, `armed`=0.
  - All outputs hold these values while `rst` is low.
- Per rising edge, in priority order:
  1. `pat_ld`=1:
     - `pat` <= `pat_in`; `fill` <= 0; `hist` <= 0; `y` <= 0.
     - `x`/`en` are ignored this cycle.
  2. Else if `en`=1:
     - `hist_n` = {hist[PAT_W-2:0], x}.
     - `fill_n` = min(fill+1, PAT_W).
     - `match` = (fill_n==PAT_W) && (hist_n==pat).
     - `hist` <= `hist_n`; `y` <= `match`.
     - `fill` <= (match && OVERLAP==0) ? 0 : fill_n.
  3. Else (`en`=0): `hist` and `fill` hold; `y` <= 0.
- Counter:
  - If `cnt_clr`=1: `match_cnt` <= 0. Clear has priority over a simultaneous match, so that match is not counted.
  - Else if `match` and `match_cnt` != all-ones: increment.
  - At all-ones, `match_cnt` holds.
- `armed` = (`fill`==PAT_W), registered, reflecting the current `fill`.
- In non-overlap mode, `fill`=0 after a match, so the next match needs PAT_W fresh enabled bits.
- `en` gaps do not break a sequence: a match is evaluated on enabled bits only.

## Timing
- The detector is a Moore-style registered output.
- `y` goes high in the cycle after the edge that samples the final pattern bit, and lasts exactly one cycle per match.
- Back-to-back `y` pulses on consecutive cycles are legal only when OVERLAP=1 and the pattern self-overlaps (e.g. all-ones).
- `match_cnt` updates on the same edge that sets `y`.
- After `pat_ld`, the first possible match is PAT_W enabled bits later; `armed`=0 during that time.
- Reset deassertion is assumed synchronised externally. The first edge after release may sample `x`.
- Reset asserted mid-sequence discards partial history immediately. `y` drops asynchronously.
- No combinational path from `x` to `y`.

## Test plan
- Defaults (1101, OVERLAP=1): release reset, `en`=1, drive x=1,1,1,0,1,1,0,1,0 -> `y` pulses after the 5th and 8th bits; `match_cnt`=2.
- Same stream with OVERLAP=0 -> `y` pulses after the 5th bit only; `match_cnt`=1.
- `pat_ld`=1 with `pat_in`=4'b0110, then x=0,1,1,0 -> `y` pulses after the 4th bit. A `pat_ld` asserted mid-stream resets `armed` to 0 and suppresses a would-be match.
- `en` toggling 0/1 around the bits 1,1,0,1 -> exactly one `y` pulse. `y`=0 on all `en`=0 cycles.
- CNT_W=2 with six matches -> `match_cnt` saturates at 3. `cnt_clr` on the same cycle as a match -> `match_cnt`=0.
- Assert `rst`=0 after bits 1,1,0, then release and send 1 -> no `y`. All outputs read 0 during reset.
